// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: state encoding and
// default geometry of the register file and multiplier.
package stall_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  localparam int REG_W_DEF   = 3;
  localparam int MUL_LAT_DEF = 4;
  localparam int MCNT_W      = 4;
  localparam int SCNT_W      = 8;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags an ID source operand that matches the destination
// of a load still in EX. Register 0 is hardwired and never forwards a hazard.
module hazard_cmp #(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             hazard
);

  logic match_rs1;
  logic match_rs2;

  assign match_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign match_rs2 = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard    = ex_mem_read && (ex_rd != '0) && (match_rs1 || match_rs2);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: single-bubble load-use stalls, branch flush and
// a multi-cycle multiply stall, plus a saturating stall-cycle counter.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int REG_W   = REG_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_mul,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  output logic             st,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             busy,
  output logic [7:0]       stall_cnt
);

  localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MUL_LAT - 1);
  localparam logic [MCNT_W-1:0] MCNT_ONE  = MCNT_W'(1);
  localparam logic [SCNT_W-1:0] SCNT_MAX  = '1;

  state_t            state;
  logic [MCNT_W-1:0] mcnt;
  logic              hazard;
  logic              mul_issue;

  hazard_cmp #(
    .REG_W (REG_W)
  ) u_hazard_cmp (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (hazard)
  );

  // Pipeline controls must react in the same cycle as the hazard, so they are
  // decoded from the state and live inputs; reset forces them all low.
  always_comb begin
    st         = 1'b0;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (branch_taken) begin
            st         = 1'b1;
            pc_we      = 1'b1;
            ifid_flush = 1'b1;
          end else if (hazard) begin
            st = 1'b1;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
        MUL_BUSY: st = 1'b1;
        default: st = 1'b0;
      endcase
    end
  end

  assign busy      = !rst && (state == MUL_BUSY);
  assign mul_issue = (state == IDLE) && !branch_taken && !hazard && id_is_mul;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mul_issue) begin
            state <= MUL_BUSY;
            mcnt  <= MCNT_LOAD;
          end
        end
        MUL_BUSY: begin
          mcnt <= mcnt - MCNT_ONE;
          if (mcnt == MCNT_ONE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (st && (stall_cnt != SCNT_MAX)) stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios followed by random
// traffic, compared against a remaining-stall-cycles reference model.
module tb_stall_ctrl;

  localparam int REG_W = 3;
  localparam int ML    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, id_is_mul, ex_mem_read, branch_taken;
  logic             st, pc_we, ifid_we, ifid_flush, busy;
  logic [7:0]       stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int m_rem = 0;
  int m_cnt = 0;

  stall_ctrl #(.REG_W(REG_W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_mul(id_is_mul), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .st(st), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] rs1, input logic u1, input logic [2:0] rs2,
                       input logic u2, input logic [2:0] rd, input logic mr,
                       input logic mul, input logic br);
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; id_is_mul = mul; branch_taken = br;
  endtask

  // Checks the current cycle against the model, then advances one clock.
  task automatic step(input string tag);
    logic hz, e_st, e_pc, e_we, e_fl, e_bz;
    #1;
    hz = ex_mem_read && (int'(ex_rd) != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_rem > 0)         {e_st, e_pc, e_we, e_fl, e_bz} = 5'b10001;
    else if (branch_taken) {e_st, e_pc, e_we, e_fl, e_bz} = 5'b11010;
    else if (hz)           {e_st, e_pc, e_we, e_fl, e_bz} = 5'b10000;
    else                   {e_st, e_pc, e_we, e_fl, e_bz} = 5'b01100;
    chk({tag, ".st"},         8'(st),         8'(e_st));
    chk({tag, ".pc_we"},      8'(pc_we),      8'(e_pc));
    chk({tag, ".ifid_we"},    8'(ifid_we),    8'(e_we));
    chk({tag, ".ifid_flush"}, 8'(ifid_flush), 8'(e_fl));
    chk({tag, ".busy"},       8'(busy),       8'(e_bz));
    chk({tag, ".stall_cnt"},  stall_cnt,      8'(m_cnt));
    @(posedge clk);
    if (e_st && m_cnt < 255) m_cnt++;
    if (m_rem > 0) m_rem--;
    else if (!branch_taken && !hz && id_is_mul) m_rem = ML - 1;
    #2;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".rst_st"},     8'(st),         8'd0);
    chk({tag, ".rst_pc_we"},  8'(pc_we),      8'd0);
    chk({tag, ".rst_ifwe"},   8'(ifid_we),    8'd0);
    chk({tag, ".rst_flush"},  8'(ifid_flush), 8'd0);
    chk({tag, ".rst_busy"},   8'(busy),       8'd0);
    chk({tag, ".rst_cnt"},    stall_cnt,      8'd0);
    m_rem = 0;
    m_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    do_reset("init");

    // Load-use on rs1: one bubble, stall_cnt 0 -> 1
    drive(3'd3, 1'b1, 3'd5, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    step("loaduse");
    drive(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    #1 chk("loaduse.cnt_after", stall_cnt, 8'd1);
    step("after_lu");

    // Register 0 never hazards
    drive(3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step("zero_reg");

    // Load-use via rs2 only, and rs1 match with use flag low
    drive(3'd6, 1'b0, 3'd6, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    step("lu_rs2");
    drive(3'd6, 1'b0, 3'd1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    step("no_use");

    // Multiply: issue at N, stall N+1..N+3, free at N+4
    drive(3'd1, 1'b1, 3'd2, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    step("mul_n");
    drive(3'd4, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < ML; i++) begin
      #1 chk("mul_busy_const", 8'(busy), 8'd1);
      step("mul_busy");
    end
    drive(3'd1, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("mul_done_const", 8'(st), 8'd0);
    step("mul_done");

    // Branch with active load-use: flush wins
    drive(3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1);
    step("br_hz");
    drive(3'd1, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("br_no_mul", 8'(busy), 8'd0);
    step("br_after");

    // Mul under load-use: bubble first, mul on the next clean cycle
    drive(3'd5, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
    step("mul_hz");
    drive(3'd5, 1'b1, 3'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0);
    step("mul_late_issue");
    drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ML; i++) step("mul_late_run");

    // Reset at N+2 of a multiply stall
    drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    step("rmul_n");
    drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("rmul_n1");
    do_reset("rmul_n2");
    #1 chk("rmul_post_busy", 8'(busy), 8'd0);
    chk("rmul_post_st", 8'(st), 8'd0);
    step("rmul_post");

    // Saturation over 300 stall cycles
    drive(3'd7, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step("sat");
    #1 chk("sat_const", stall_cnt, 8'd255);
    step("sat_hold");
    do_reset("post_sat");

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      drive(3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
            1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 59) == 0) do_reset("rnd");
      else step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
